// File: rtl/rgb_key_cipher_stream.sv
// RGB pixel XOR cipher stage: a key FIFO fed by the key generator supplies one
// {r,g,b} triple per pixel; optional ciphertext chaining; one frame per start.
module rgb_key_cipher_stream #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_PIXELS = 1024,
  parameter bit          CHAIN_EN   = 1'b1,
  parameter logic [23:0] IV         = 24'h5A_A5_3C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [7:0]               key_r,
  input  logic [7:0]               key_g,
  input  logic [7:0]               key_b,
  input  logic                     start,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [7:0]               pix_r,
  input  logic [7:0]               pix_g,
  input  logic [7:0]               pix_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_r,
  output logic [7:0]               out_g,
  output logic [7:0]               out_b,
  output logic [$clog2(DEPTH):0]   key_level,
  output logic                     overflow,
  output logic [15:0]              pix_count,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [15:0]   LAST_PIX  = 16'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          out_valid_q, out_valid_d;
  logic [23:0]   out_data_q, out_data_d;
  logic [23:0]   chain_q, chain_d;
  logic [15:0]   count_q, count_d;
  logic          done_q, done_d;

  logic        fifo_full, fifo_empty;
  logic        hs, push, pop;
  logic [23:0] key_head, cipher;

  assign fifo_full  = (level_q == DEPTH_LVL);
  assign fifo_empty = (level_q == '0);

  // Output register may take a new pixel when empty or draining this cycle.
  assign pix_ready = (state_q == ST_RUN) && !fifo_empty && (!out_valid_q || out_ready);
  assign hs        = pix_valid && pix_ready;
  assign pop       = hs;
  assign push      = key_valid && (!fifo_full || pop);

  assign key_head = mem_q[rd_ptr_q];
  assign cipher   = {pix_r, pix_g, pix_b} ^ key_head ^ (CHAIN_EN ? chain_q : 24'h0);

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    chain_d     = chain_q;
    count_d     = count_q;
    done_d      = done_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (key_valid && !push) overflow_d = 1'b1;

    if (hs) begin
      out_data_d  = cipher;
      out_valid_d = 1'b1;
      count_d     = count_q + 16'd1;
      if (CHAIN_EN) chain_d = cipher;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        chain_d = IV;
        done_d  = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hs && count_q == LAST_PIX) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          chain_d = IV;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      chain_q     <= IV;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      chain_q     <= chain_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  // NOTE: key storage is not reset; the cleared pointers and level make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {key_r, key_g, key_b};
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_data_q[23:16];
  assign out_g     = out_data_q[15:8];
  assign out_b     = out_data_q[7:0];
  assign key_level = level_q;
  assign overflow  = overflow_q;
  assign pix_count = count_q;
  assign done      = done_q;

endmodule
